// File: rtl/sm_clk_divider_ex.sv
// Multi-mode clock generator: power-of-two tap, integer divide, manual
// single-step pulse and hold. Configuration changes only take effect at
// period boundaries, so clkOut never glitches. tick marks each rising edge.
module sm_clk_divider_ex #(
  parameter int CNT_WIDTH = 32,
  parameter int DIV_WIDTH = 16,
  parameter int SHIFT     = 16,
  parameter int STEP_HI   = 4
) (
  input  logic                 clkIn,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [3:0]           shift_sel,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 step,
  output logic                 clkOut,
  output logic                 tick,
  output logic [1:0]           active_mode
);

  localparam int TAP_W = $clog2(CNT_WIDTH);
  localparam int PW    = $clog2(STEP_HI + 1);

  typedef enum logic [1:0] {
    MODE_POW2 = 2'd0,
    MODE_INT  = 2'd1,
    MODE_STEP = 2'd2,
    MODE_HOLD = 2'd3
  } mode_t;

  mode_t                active_q;
  logic [3:0]           active_shift;
  logic [DIV_WIDTH-1:0] active_div;
  logic [CNT_WIDTH-1:0] cnt;
  logic [PW-1:0]        pulse_cnt;
  logic                 step_meta, step_sync1, step_sync2;

  logic [CNT_WIDTH-1:0] cnt_next, cnt_inc, tap_mask;
  logic [PW-1:0]        pulse_next;
  logic                 clk_next, boundary;
  logic [TAP_W-1:0]     tap;
  logic [DIV_WIDTH-1:0] eff_div, half_div, cnt_low, cnt_inc_low;
  logic                 pow2_wrap, int_wrap, step_edge, idle;

  assign active_mode = active_q;

  // Derived quantities shared by the per-mode period logic
  assign tap         = TAP_W'(SHIFT) + TAP_W'(active_shift);
  assign tap_mask    = {CNT_WIDTH{1'b1}} >> (TAP_W'(CNT_WIDTH - 1) - tap);
  assign cnt_inc     = cnt + 1'b1;
  assign pow2_wrap   = (cnt & tap_mask) == tap_mask;
  assign eff_div     = (active_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : active_div;
  assign half_div    = eff_div >> 1;
  assign cnt_low     = cnt[DIV_WIDTH-1:0];
  assign cnt_inc_low = cnt_low + 1'b1;
  assign int_wrap    = cnt_low == (eff_div - 1'b1);
  assign step_edge   = step_sync1 & ~step_sync2;
  assign idle        = pulse_cnt == '0;

  // Synchronize the asynchronous step button and keep one extra stage for edge detect
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      step_meta  <= 1'b0;
      step_sync1 <= 1'b0;
      step_sync2 <= 1'b0;
    end else begin
      step_meta  <= step;
      step_sync1 <= step_meta;
      step_sync2 <= step_sync1;
    end
  end

  // Next counter, clock level and pulse count for the applied mode; detect boundaries
  always_comb begin
    cnt_next   = cnt;
    clk_next   = clkOut;
    pulse_next = pulse_cnt;
    boundary   = 1'b0;
    if (enable) begin
      case (active_q)
        MODE_POW2: begin
          if (pow2_wrap) begin
            boundary = 1'b1;
          end else begin
            cnt_next = cnt_inc;
            clk_next = cnt_inc[tap];
          end
        end
        MODE_INT: begin
          if (int_wrap) begin
            boundary = 1'b1;
          end else begin
            cnt_next = cnt_inc;
            clk_next = cnt_inc_low >= half_div;
          end
        end
        MODE_STEP: begin
          if (!idle) begin
            pulse_next = pulse_cnt - 1'b1;
            if (pulse_cnt == PW'(1)) clk_next = 1'b0;
          end else if (step_edge) begin
            clk_next   = 1'b1;
            pulse_next = PW'(STEP_HI);
          end else begin
            boundary = 1'b1;
          end
        end
        default: begin
          boundary = 1'b1;
        end
      endcase
    end
    if (boundary) begin
      cnt_next = '0;
      clk_next = 1'b0;
    end
  end

  // Period state and registered outputs
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      pulse_cnt <= '0;
      clkOut    <= 1'b0;
      tick      <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      pulse_cnt <= pulse_next;
      clkOut    <= clk_next;
      tick      <= enable & ~clkOut & clk_next;
    end
  end

  // Applied configuration only reloads on a boundary cycle
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      active_q     <= MODE_HOLD;
      active_shift <= 4'd0;
      active_div   <= DIV_WIDTH'(2);
    end else if (boundary) begin
      active_q     <= mode_t'(mode);
      active_shift <= shift_sel;
      active_div   <= div;
    end
  end

endmodule
